// File: rtl/por_reset_sequencer.sv
// Power-on reset sequencer: qualifies a synchronized PLL lock, then releases
// peripheral and core resets in order and tracks lock-loss events.
module por_reset_sequencer #(
  parameter int SYNC_STAGES        = 2,
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int PERIPH_HOLD_CYCLES = 16,
  parameter int CORE_HOLD_CYCLES   = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       lock_in,
  input  logic       lost_clear,
  output logic       sys_reset_periph,
  output logic       sys_reset_core,
  output logic       ready,
  output logic       lock_lost_pulse,
  output logic [7:0] lock_lost_count
);

  localparam int HOLD_MAX = (PERIPH_HOLD_CYCLES > CORE_HOLD_CYCLES) ?
                            PERIPH_HOLD_CYCLES : CORE_HOLD_CYCLES;
  localparam int CNT_MAX  = (LOCK_STABLE_CYCLES > HOLD_MAX) ? LOCK_STABLE_CYCLES : HOLD_MAX;
  localparam int CNT_W    = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] QUAL_LAST   = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] PERIPH_LAST = CNT_W'(PERIPH_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] CORE_LAST   = CNT_W'(CORE_HOLD_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    QUALIFY     = 3'd1,
    HOLD_PERIPH = 3'd2,
    HOLD_CORE   = 3'd3,
    RUN         = 3'd4
  } state_t;

  state_t                   state_reg, state_next;
  logic [CNT_W-1:0]         cnt_reg, cnt_next;
  logic [SYNC_STAGES-1:0]   sync_reg, sync_next;
  logic                     lock_sync;
  logic                     periph_reg, periph_next;
  logic                     core_reg, core_next;
  logic                     ready_reg, ready_next;
  logic                     pulse_reg, pulse_next;
  logic [7:0]               count_reg, count_next;

  // Only the first stage ever looks at the raw, asynchronous lock input.
  generate
    for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      if (gi == 0) begin : g_first
        assign sync_next[gi] = lock_in;
      end else begin : g_rest
        assign sync_next[gi] = sync_reg[gi-1];
      end
    end
  endgenerate

  assign lock_sync = sync_reg[SYNC_STAGES-1];

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      sync_reg   <= '0;
      periph_reg <= 1'b1;
      core_reg   <= 1'b1;
      ready_reg  <= 1'b0;
      pulse_reg  <= 1'b0;
      count_reg  <= 8'd0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      sync_reg   <= sync_next;
      periph_reg <= periph_next;
      core_reg   <= core_next;
      ready_reg  <= ready_next;
      pulse_reg  <= pulse_next;
      count_reg  <= count_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (lock_sync) begin
          state_next = QUALIFY;
          cnt_next   = '0;
        end
      end
      QUALIFY: begin
        if (cnt_reg == QUAL_LAST) begin
          state_next = HOLD_PERIPH;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      HOLD_PERIPH: begin
        if (cnt_reg == PERIPH_LAST) begin
          state_next = HOLD_CORE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      HOLD_CORE: begin
        if (cnt_reg == CORE_LAST) begin
          state_next = RUN;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      RUN: begin
        cnt_next = '0;
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
    // A lost lock overrides whatever terminal transition was pending.
    if (state_reg != IDLE && !lock_sync) begin
      state_next = IDLE;
      cnt_next   = '0;
    end
  end

  // Outputs are decoded from the next state so the pins come straight off flops.
  always_comb begin
    periph_next = (state_next == IDLE) || (state_next == QUALIFY) ||
                  (state_next == HOLD_PERIPH);
    core_next   = (state_next != RUN);
    ready_next  = (state_next == RUN);
    pulse_next  = !lock_sync && ((state_reg == HOLD_CORE) || (state_reg == RUN));
    count_next  = count_reg;
    if (pulse_next) begin
      if (lost_clear) begin
        count_next = 8'd1;
      end else if (count_reg != 8'hFF) begin
        count_next = count_reg + 8'd1;
      end
    end else if (lost_clear) begin
      count_next = 8'd0;
    end
  end

  assign sys_reset_periph = periph_reg;
  assign sys_reset_core   = core_reg;
  assign ready            = ready_reg;
  assign lock_lost_pulse  = pulse_reg;
  assign lock_lost_count  = count_reg;

endmodule
